// File: rtl/mem_stage_if.sv
// mem_stage_if: execute->memory->write-back link plus data-SRAM read data
// and the decode forwarding path. Bus width follows MS_LOAD_EXT_EN
// (74-bit execute bus with mem_op prepended when defined, 71-bit otherwise).
interface mem_stage_if;
`ifdef MS_LOAD_EXT_EN
  localparam int ES_BUS_W = 74;
`else
  localparam int ES_BUS_W = 71;
`endif

  logic                es_to_ms_valid;
  logic [ES_BUS_W-1:0] es_to_ms_bus;
  logic                ms_allowin;
  logic                ws_allowin;
  logic [31:0]         data_sram_rdata;
  logic                ms_to_ws_valid;
  logic [69:0]         ms_to_ws_bus;
  logic [4:0]          ms_to_ds_dest;
  logic [31:0]         ms_to_ds_value;

  // Memory stage side
  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_dest, ms_to_ds_value
  );

  // Surrounding pipeline side
  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_dest, ms_to_ds_value
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: fourth pipeline stage. Registers the execute bus, collects the
// synchronous SRAM read data for loads (held locally across write-back
// stalls), selects the write-back value and forwards dest/value to decode.
// Optional macro MS_LOAD_EXT_EN adds LB/LH/LBU/LHU sub-word load extension.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  ms_if
);
`ifdef MS_LOAD_EXT_EN
  localparam int ES_BUS_W = 74;
`else
  localparam int ES_BUS_W = 71;
`endif

  logic                ms_valid_q;
  logic                hold_vld_q;
  logic [31:0]         rdata_hold_q;
  logic [ES_BUS_W-1:0] es_bus_q;

  logic        ms_ready_go;
  logic        ms_allowin;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] mem_word;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        fwd_en;

  assign ms_ready_go  = 1'b1;
  assign ms_allowin   = !ms_valid_q || (ms_ready_go && ms_if.ws_allowin);

  assign res_from_mem = es_bus_q[70];
  assign gr_we        = es_bus_q[69];
  assign dest         = es_bus_q[68:64];
  assign alu_result   = es_bus_q[63:32];
  assign pc           = es_bus_q[31:0];

  // Valid flag: advances whenever the stage can accept
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid_q <= ms_if.es_to_ms_valid;
    end
  end

  // Bus register: loads only on an accepted instruction, never reset
  always_ff @(posedge clk) begin
    if (ms_if.es_to_ms_valid && ms_allowin) begin
      es_bus_q <= ms_if.es_to_ms_bus;
    end
  end

  // Read-data hold: capture live SRAM data on the first stalled cycle only;
  // any cycle that lets the stage advance drops the held copy
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld_q <= 1'b0;
    end else if (ms_allowin) begin
      hold_vld_q <= 1'b0;
    end else if (ms_valid_q && !hold_vld_q && !ms_if.ws_allowin) begin
      hold_vld_q   <= 1'b1;
      rdata_hold_q <= ms_if.data_sram_rdata;
    end
  end

  assign mem_word = hold_vld_q ? rdata_hold_q : ms_if.data_sram_rdata;

`ifdef MS_LOAD_EXT_EN
  logic [2:0]  mem_op;
  logic [1:0]  addr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign mem_op = es_bus_q[73:71];
  assign addr   = alu_result[1:0];

  // Sub-word extraction and extension; unaligned halfword uses addr[1] only
  always_comb begin
    byte_sel  = mem_word[7:0];
    half_sel  = addr[1] ? mem_word[31:16] : mem_word[15:0];
    load_data = mem_word;
    case (addr)
      2'd0: byte_sel = mem_word[7:0];
      2'd1: byte_sel = mem_word[15:8];
      2'd2: byte_sel = mem_word[23:16];
      2'd3: byte_sel = mem_word[31:24];
      default: byte_sel = mem_word[7:0];
    endcase
    case (mem_op)
      3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = mem_word;
    endcase
  end
`else
  assign load_data = mem_word;
`endif

  assign final_result = res_from_mem ? load_data : alu_result;

  assign ms_if.ms_allowin     = ms_allowin;
  assign ms_if.ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign ms_if.ms_to_ws_bus   = {gr_we, dest, final_result, pc};

  assign fwd_en               = ms_valid_q && gr_we;
  assign ms_if.ms_to_ds_dest  = {5{fwd_en}} & dest;
  assign ms_if.ms_to_ds_value = {32{fwd_en}} & final_result;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Builds in both configurations; MS_LOAD_EXT_EN adds the sub-word load test.
module tb_mem_stage;
`ifdef MS_LOAD_EXT_EN
  localparam int ES_BUS_W = 74;
`else
  localparam int ES_BUS_W = 71;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_stage_if ms_if ();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .ms_if (ms_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ES_BUS_W-1:0] mk_bus(input logic [2:0] op, input logic rfm,
                                                 input logic we, input logic [4:0] dst,
                                                 input logic [31:0] alu, input logic [31:0] pc);
    logic [73:0] full;
    full = {op, rfm, we, dst, alu, pc};
    return full[ES_BUS_W-1:0];
  endfunction

  // advance past the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.es_to_ms_bus    = '0;
    ms_if.ws_allowin      = 1'b1;
    ms_if.data_sram_rdata = '0;
    step();
    step();
    #1;
    checks++; if (ms_if.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", ms_if.ms_to_ws_valid); end
    checks++; if (ms_if.ms_to_ds_dest !== 5'd0) begin errors++; $display("FAIL rst_dest got %0d want 0", ms_if.ms_to_ds_dest); end
    checks++; if (ms_if.ms_to_ds_value !== 32'd0) begin errors++; $display("FAIL rst_value got %h want 0", ms_if.ms_to_ds_value); end
    checks++; if (ms_if.ms_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin got %0b want 1", ms_if.ms_allowin); end
    reset = 1'b0;
  endtask

  task automatic test_alu_pass();
    ms_if.ws_allowin     = 1'b1;
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk_bus(3'b000, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000);
    step();
    ms_if.es_to_ms_valid  = 1'b1;
    ms_if.es_to_ms_bus    = mk_bus(3'b000, 1'b0, 1'b0, 5'd9, 32'hAAAA_5555, 32'h0000_1004);
    ms_if.data_sram_rdata = 32'h5A5A_5A5A;
    #1;
    checks++; if (ms_if.ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got %0b want 1", ms_if.ms_to_ws_valid); end
    checks++; if (ms_if.ms_to_ws_bus !== {1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000}) begin errors++; $display("FAIL alu_bus got %h want %h", ms_if.ms_to_ws_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000}); end
    checks++; if (ms_if.ms_to_ds_dest !== 5'd5) begin errors++; $display("FAIL alu_fwd_dest got %0d want 5", ms_if.ms_to_ds_dest); end
    checks++; if (ms_if.ms_to_ds_value !== 32'h1234_5678) begin errors++; $display("FAIL alu_fwd_value got %h want 12345678", ms_if.ms_to_ds_value); end
    step();
    ms_if.es_to_ms_valid = 1'b0;
    #1;
    // gr_we=0 instruction: valid to write-back, no forwarding
    checks++; if (ms_if.ms_to_ws_bus[63:32] !== 32'hAAAA_5555) begin errors++; $display("FAIL nowe_result got %h want aaaa5555", ms_if.ms_to_ws_bus[63:32]); end
    checks++; if (ms_if.ms_to_ds_dest !== 5'd0 || ms_if.ms_to_ds_value !== 32'd0) begin errors++; $display("FAIL nowe_fwd got %0d/%h want 0/0", ms_if.ms_to_ds_dest, ms_if.ms_to_ds_value); end
    step();
    #1;
    checks++; if (ms_if.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL empty_valid got %0b want 0", ms_if.ms_to_ws_valid); end
    checks++; if (ms_if.ms_to_ds_dest !== 5'd0 || ms_if.ms_to_ds_value !== 32'd0) begin errors++; $display("FAIL empty_fwd got %0d/%h want 0/0", ms_if.ms_to_ds_dest, ms_if.ms_to_ds_value); end
  endtask

  task automatic test_load_nostall();
    ms_if.ws_allowin     = 1'b1;
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk_bus(3'b000, 1'b1, 1'b1, 5'd3, 32'h0000_0040, 32'h0000_2000);
    step();
    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.data_sram_rdata = 32'hCAFE_BABE;
    #1;
    checks++; if (ms_if.ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL ld_valid got %0b want 1", ms_if.ms_to_ws_valid); end
    checks++; if (ms_if.ms_to_ws_bus[63:32] !== 32'hCAFE_BABE) begin errors++; $display("FAIL ld_result got %h want cafebabe", ms_if.ms_to_ws_bus[63:32]); end
    checks++; if (ms_if.ms_to_ds_value !== 32'hCAFE_BABE) begin errors++; $display("FAIL ld_fwd got %h want cafebabe", ms_if.ms_to_ds_value); end
    step();
    #1;
    checks++; if (ms_if.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL ld_one_cycle got %0b want 0", ms_if.ms_to_ws_valid); end
  endtask

  task automatic test_load_stall_back_to_back();
    ms_if.ws_allowin     = 1'b1;
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk_bus(3'b000, 1'b1, 1'b1, 5'd4, 32'h0000_0080, 32'h0000_3000);
    step();
    // MS cycle 1: live data, write-back stalls
    ms_if.es_to_ms_valid  = 1'b1;
    ms_if.es_to_ms_bus    = mk_bus(3'b000, 1'b1, 1'b1, 5'd7, 32'h0000_0084, 32'h0000_3004);
    ms_if.ws_allowin      = 1'b0;
    ms_if.data_sram_rdata = 32'hCAFE_BABE;
    for (int unsigned c = 1; c <= 3; c++) begin
      #1;
      checks++; if (ms_if.ms_to_ws_bus !== {1'b1, 5'd4, 32'hCAFE_BABE, 32'h0000_3000}) begin errors++; $display("FAIL stall_bus c%0d got %h want %h", c, ms_if.ms_to_ws_bus, {1'b1, 5'd4, 32'hCAFE_BABE, 32'h0000_3000}); end
      checks++; if (ms_if.ms_allowin !== 1'b0) begin errors++; $display("FAIL stall_allowin c%0d got %0b want 0", c, ms_if.ms_allowin); end
      step();
      ms_if.data_sram_rdata = 32'hDEAD_0000;
    end
    // MS cycle 4: stall released, second load offered
    ms_if.ws_allowin = 1'b1;
    #1;
    checks++; if (ms_if.ms_to_ws_bus[63:32] !== 32'hCAFE_BABE) begin errors++; $display("FAIL release_result got %h want cafebabe", ms_if.ms_to_ws_bus[63:32]); end
    checks++; if (ms_if.ms_allowin !== 1'b1) begin errors++; $display("FAIL release_allowin got %0b want 1", ms_if.ms_allowin); end
    step();
    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.data_sram_rdata = 32'h0000_00FF;
    #1;
    checks++; if (ms_if.ms_to_ws_bus !== {1'b1, 5'd7, 32'h0000_00FF, 32'h0000_3004}) begin errors++; $display("FAIL b2b_bus got %h want %h", ms_if.ms_to_ws_bus, {1'b1, 5'd7, 32'h0000_00FF, 32'h0000_3004}); end
    checks++; if (ms_if.ms_to_ds_dest !== 5'd7) begin errors++; $display("FAIL b2b_dest got %0d want 7", ms_if.ms_to_ds_dest); end
    step();
    #1;
  endtask

  task automatic test_reset_stall();
    ms_if.ws_allowin     = 1'b1;
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk_bus(3'b000, 1'b1, 1'b1, 5'd9, 32'h0000_0100, 32'h0000_4000);
    step();
    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.ws_allowin      = 1'b0;
    ms_if.data_sram_rdata = 32'h1357_9BDF;
    step();
    ms_if.data_sram_rdata = 32'h0BAD_0BAD;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++; if (ms_if.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL rststall_valid got %0b want 0", ms_if.ms_to_ws_valid); end
    checks++; if (ms_if.ms_to_ds_dest !== 5'd0) begin errors++; $display("FAIL rststall_dest got %0d want 0", ms_if.ms_to_ds_dest); end
    checks++; if (ms_if.ms_allowin !== 1'b1) begin errors++; $display("FAIL rststall_allowin got %0b want 1", ms_if.ms_allowin); end
    // first load after reset must see live data, not the stale held word
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk_bus(3'b000, 1'b1, 1'b1, 5'd10, 32'h0000_0104, 32'h0000_4004);
    step();
    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.data_sram_rdata = 32'h1111_2222;
    #1;
    checks++; if (ms_if.ms_to_ws_bus[63:32] !== 32'h1111_2222) begin errors++; $display("FAIL post_rst_live got %h want 11112222", ms_if.ms_to_ws_bus[63:32]); end
    ms_if.ws_allowin = 1'b1;
    step();
  endtask

`ifdef MS_LOAD_EXT_EN
  task automatic test_load_ext();
    logic [2:0]  ops [5];
    logic [31:0] adr [5];
    logic [31:0] exp [5];
    ops[0] = 3'b001; adr[0] = 32'h0000_0203; exp[0] = 32'hFFFF_FF80;
    ops[1] = 3'b100; adr[1] = 32'h0000_0203; exp[1] = 32'h0000_0080;
    ops[2] = 3'b010; adr[2] = 32'h0000_0202; exp[2] = 32'hFFFF_80FF;
    ops[3] = 3'b101; adr[3] = 32'h0000_0200; exp[3] = 32'h0000_7F01;
    ops[4] = 3'b011; adr[4] = 32'h0000_0201; exp[4] = 32'h80FF_7F01;
    ms_if.ws_allowin = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      ms_if.es_to_ms_valid = 1'b1;
      ms_if.es_to_ms_bus   = mk_bus(ops[i], 1'b1, 1'b1, 5'd12, adr[i], 32'h0000_5000);
      step();
      ms_if.es_to_ms_valid  = 1'b0;
      ms_if.data_sram_rdata = 32'h80FF_7F01;
      #1;
      checks++; if (ms_if.ms_to_ws_bus[63:32] !== exp[i]) begin errors++; $display("FAIL ext_op%0d got %h want %h", i, ms_if.ms_to_ws_bus[63:32], exp[i]); end
    end
    step();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu_pass();
    test_load_nostall();
    test_load_stall_back_to_back();
    test_reset_stall();
`ifdef MS_LOAD_EXT_EN
    test_load_ext();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
